// File: rtl/kb_grid_pkg.sv
// kb_grid_pkg: scan codes, prefix states and digit lookup for the grid cursor
package kb_grid_pkg;
  localparam logic [7:0] KC_E0  = 8'hE0;
  localparam logic [7:0] KC_F0  = 8'hF0;
  localparam logic [7:0] KC_UP  = 8'h75;
  localparam logic [7:0] KC_DN  = 8'h72;
  localparam logic [7:0] KC_LT  = 8'h6B;
  localparam logic [7:0] KC_RT  = 8'h74;
  localparam logic [7:0] KC_ESC = 8'h76;
  localparam logic [7:0] KC_DIGIT [0:8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  typedef enum logic [1:0] {IDLE, EXT, BRK} pfx_t;
  function automatic logic [4:0] digit_slot(input logic [7:0] b);
    digit_slot = '0;
    for (int i = 0; i < 9; i++)
      if (b == KC_DIGIT[i]) digit_slot = {1'b1, 4'(i)};
  endfunction
endpackage

// File: rtl/kb_scan_decoder.sv
// kb_scan_decoder: E0/F0 prefix tracking, turns make codes into action strobes
module kb_scan_decoder
  import kb_grid_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       new_kb,
  input  logic [7:0] kb_dat,
  output logic       mv_r,
  output logic       mv_l,
  output logic       mv_u,
  output logic       mv_d,
  output logic       cap_en,
  output logic [3:0] cap_idx,
  output logic       esc
);
  pfx_t st, nxt;
  logic act, idle;
  logic [4:0] ds;
  always_comb begin
    nxt  = st == BRK ? IDLE : kb_dat == KC_F0 ? BRK : (st == IDLE && kb_dat == KC_E0) ? EXT : IDLE;
    act  = new_kb && st != BRK;
    idle = new_kb && st == IDLE;
    ds   = digit_slot(kb_dat);
    mv_r = act && kb_dat == KC_RT;
    mv_l = act && kb_dat == KC_LT;
    mv_u = act && kb_dat == KC_UP;
    mv_d = act && kb_dat == KC_DN;
    cap_en  = idle && ds[4];
    cap_idx = ds[3:0];
    esc  = idle && kb_dat == KC_ESC;
  end
  always_ff @(posedge clk)
    if (reset || clear) st <= IDLE;
    else if (new_kb) st <= nxt;
endmodule

// File: rtl/kb_grid_cursor.sv
// kb_grid_cursor: keyboard-driven (x,y) grid cursor with capture slots
module kb_grid_cursor
  import kb_grid_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  parameter int SLOTS = 2,
  parameter bit WRAP = 1'b1,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS),
  localparam int DW = XW + YW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  new_kb,
  input  logic [7:0]            kb_dat,
  output logic [XW-1:0]         xcoord,
  output logic [YW-1:0]         ycoord,
  output logic [SLOTS*DW-1:0]   sel_data,
  output logic [SLOTS-1:0]      sel_valid,
  output logic [SLOTS-1:0]      sel_pulse,
  output logic                  moved
);
  localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);
  logic mv_r, mv_l, mv_u, mv_d, cap_en, esc;
  logic [3:0] cap_idx;
  logic [XW-1:0] xn;
  logic [YW-1:0] yn;
  logic [SLOTS-1:0] cap_mask;
  kb_scan_decoder u_dec (
    .clk(clk), .reset(reset), .clear(clear), .new_kb(new_kb), .kb_dat(kb_dat),
    .mv_r(mv_r), .mv_l(mv_l), .mv_u(mv_u), .mv_d(mv_d),
    .cap_en(cap_en), .cap_idx(cap_idx), .esc(esc)
  );
  // edges compared explicitly so non-power-of-2 grids wrap correctly
  always_comb begin
    xn = mv_r ? (xcoord == XMAX ? (WRAP ? '0 : xcoord) : xcoord + 1'b1)
       : mv_l ? (xcoord == '0 ? (WRAP ? XMAX : xcoord) : xcoord - 1'b1) : xcoord;
    yn = mv_d ? (ycoord == YMAX ? (WRAP ? '0 : ycoord) : ycoord + 1'b1)
       : mv_u ? (ycoord == '0 ? (WRAP ? YMAX : ycoord) : ycoord - 1'b1) : ycoord;
    cap_mask = '0;
    for (int k = 0; k < SLOTS; k++) cap_mask[k] = cap_en && cap_idx == 4'(k);
  end
  always_ff @(posedge clk)
    if (reset || clear) begin
      xcoord    <= '0;
      ycoord    <= '0;
      sel_data  <= '0;
      sel_valid <= '0;
      sel_pulse <= '0;
      moved     <= 1'b0;
    end else begin
      xcoord    <= xn;
      ycoord    <= yn;
      moved     <= xn != xcoord || yn != ycoord;
      sel_pulse <= cap_mask;
      sel_valid <= esc ? '0 : sel_valid | cap_mask;
      for (int k = 0; k < SLOTS; k++)
        if (cap_mask[k]) sel_data[k*DW +: DW] <= {xcoord, ycoord};
    end
endmodule

// File: tb/tb_kb_grid_cursor.sv
// tb_kb_grid_cursor: vector table, corner sequences and random bytes vs a reference model
module tb_kb_grid_cursor;
  logic clk = 0, reset = 1, clear = 0, new_kb = 0;
  logic [7:0] kb_dat = 0;
  logic [1:0] x0, y0, v0, p0;
  logic [7:0] d0;
  logic m0;
  logic [2:0] x1, v1, p1;
  logic [1:0] y1;
  logic [14:0] d1;
  logic m1;
  int nchk = 0, nfail = 0;
  always #5 clk = ~clk;

  kb_grid_cursor #(.COLS(4), .ROWS(4), .SLOTS(2), .WRAP(1'b1)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .new_kb(new_kb), .kb_dat(kb_dat),
    .xcoord(x0), .ycoord(y0), .sel_data(d0), .sel_valid(v0), .sel_pulse(p0), .moved(m0));
  kb_grid_cursor #(.COLS(5), .ROWS(3), .SLOTS(3), .WRAP(1'b0)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .new_kb(new_kb), .kb_dat(kb_dat),
    .xcoord(x1), .ycoord(y1), .sel_data(d1), .sel_valid(v1), .sel_pulse(p1), .moved(m1));

  int cols[2] = '{4, 5};
  int rows[2] = '{4, 3};
  int slots[2] = '{2, 3};
  bit wrap[2] = '{1'b1, 1'b0};
  int yw[2] = '{2, 2};
  int dw[2] = '{4, 5};
  int dig[9] = '{'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
  int mx[2], my[2], sx[2][9], sy[2][9];
  bit sv[2][9], sp[2][9], mmv[2], ext_seen, brk_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int movec(int v, int dir, int n, bit w);
    int t = v + dir;
    if (w) return (t + n) % n;
    return t < 0 ? 0 : t >= n ? n - 1 : t;
  endfunction

  task automatic model(input bit rc, input bit nk, input int b);
    for (int d = 0; d < 2; d++) begin
      mmv[d] = 0;
      for (int k = 0; k < 9; k++) sp[d][k] = 0;
    end
    if (rc) begin
      ext_seen = 0; brk_seen = 0;
      for (int d = 0; d < 2; d++) begin
        mx[d] = 0; my[d] = 0;
        for (int k = 0; k < 9; k++) begin sx[d][k] = 0; sy[d][k] = 0; sv[d][k] = 0; end
      end
    end else if (nk) begin
      if (brk_seen) begin brk_seen = 0; ext_seen = 0; end
      else if (b == 'hF0) begin brk_seen = 1; ext_seen = 0; end
      else if (!ext_seen && b == 'hE0) ext_seen = 1;
      else begin
        for (int d = 0; d < 2; d++) begin
          int ox = mx[d], oy = my[d];
          if (b == 'h74) mx[d] = movec(mx[d], 1, cols[d], wrap[d]);
          if (b == 'h6B) mx[d] = movec(mx[d], -1, cols[d], wrap[d]);
          if (b == 'h72) my[d] = movec(my[d], 1, rows[d], wrap[d]);
          if (b == 'h75) my[d] = movec(my[d], -1, rows[d], wrap[d]);
          mmv[d] = ox != mx[d] || oy != my[d];
          if (!ext_seen) begin
            for (int k = 0; k < 9; k++)
              if (b == dig[k] && k < slots[d]) begin
                sx[d][k] = ox; sy[d][k] = oy; sv[d][k] = 1; sp[d][k] = 1;
              end
            if (b == 'h76) for (int k = 0; k < 9; k++) sv[d][k] = 0;
          end
        end
        ext_seen = 0;
      end
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] ed = 0, ev = 0, ep = 0;
      for (int k = 0; k < slots[d]; k++) begin
        ed |= 32'(((sx[d][k] << yw[d]) | sy[d][k]) << (k * dw[d]));
        ev[k] = sv[d][k];
        ep[k] = sp[d][k];
      end
      chk($sformatf("x%0d", d), d ? 32'(x1) : 32'(x0), 32'(mx[d]));
      chk($sformatf("y%0d", d), d ? 32'(y1) : 32'(y0), 32'(my[d]));
      chk($sformatf("data%0d", d), d ? 32'(d1) : 32'(d0), ed);
      chk($sformatf("valid%0d", d), d ? 32'(v1) : 32'(v0), ev);
      chk($sformatf("pulse%0d", d), d ? 32'(p1) : 32'(p0), ep);
      chk($sformatf("moved%0d", d), d ? 32'(m1) : 32'(m0), 32'(mmv[d]));
    end
  endtask

  task automatic step(input bit r, input bit c, input bit nk, input logic [7:0] b);
    reset = r; clear = c; new_kb = nk; kb_dat = b;
    @(posedge clk);
    #1;
    reset = 0; clear = 0; new_kb = 0;
    model(r | c, nk, int'(b));
    compare();
  endtask

  typedef struct {
    bit nk; bit clr; logic [7:0] dat;
    logic [1:0] ex, ey; logic [7:0] edata; logic [1:0] evalid, epulse; bit emoved;
  } vec_t;
  vec_t tbl[20];

  initial begin
    int mcount;
    tbl = '{
      '{1, 0, 8'h74, 1, 0, 8'h00, 0, 0, 1}, '{1, 0, 8'h74, 2, 0, 8'h00, 0, 0, 1},
      '{1, 0, 8'h72, 2, 1, 8'h00, 0, 0, 1}, '{1, 0, 8'h16, 2, 1, 8'h09, 1, 1, 0},
      '{0, 0, 8'h00, 2, 1, 8'h09, 1, 0, 0}, '{1, 0, 8'hE0, 2, 1, 8'h09, 1, 0, 0},
      '{1, 0, 8'h74, 3, 1, 8'h09, 1, 0, 1}, '{1, 0, 8'hE0, 3, 1, 8'h09, 1, 0, 0},
      '{1, 0, 8'hF0, 3, 1, 8'h09, 1, 0, 0}, '{1, 0, 8'h74, 3, 1, 8'h09, 1, 0, 0},
      '{1, 0, 8'hF0, 3, 1, 8'h09, 1, 0, 0}, '{1, 0, 8'h16, 3, 1, 8'h09, 1, 0, 0},
      '{1, 0, 8'h74, 0, 1, 8'h09, 1, 0, 1}, '{1, 0, 8'h6B, 3, 1, 8'h09, 1, 0, 1},
      '{1, 0, 8'h75, 3, 0, 8'h09, 1, 0, 1}, '{1, 0, 8'h75, 3, 3, 8'h09, 1, 0, 1},
      '{1, 0, 8'h26, 3, 3, 8'h09, 1, 0, 0}, '{1, 0, 8'h1E, 3, 3, 8'hF9, 3, 2, 0},
      '{1, 0, 8'h76, 3, 3, 8'hF9, 0, 0, 0}, '{1, 1, 8'h16, 0, 0, 8'h00, 0, 0, 0}};
    step(1, 0, 0, 0);
    chk("rst_x", 32'(x0), 0); chk("rst_valid", 32'(v0), 0); chk("rst_moved", 32'(m0), 0);
    for (int i = 0; i < 20; i++) begin
      step(0, tbl[i].clr, tbl[i].nk, tbl[i].dat);
      chk($sformatf("tbl%0d_x", i), 32'(x0), 32'(tbl[i].ex));
      chk($sformatf("tbl%0d_y", i), 32'(y0), 32'(tbl[i].ey));
      chk($sformatf("tbl%0d_data", i), 32'(d0), 32'(tbl[i].edata));
      chk($sformatf("tbl%0d_valid", i), 32'(v0), 32'(tbl[i].evalid));
      chk($sformatf("tbl%0d_pulse", i), 32'(p0), 32'(tbl[i].epulse));
      chk($sformatf("tbl%0d_moved", i), 32'(m0), 32'(tbl[i].emoved));
    end
    step(0, 0, 1, 8'hE0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'h16);
    chk("rst_after_e0_pulse", 32'(p0), 1);
    chk("rst_after_e0_valid", 32'(v0), 1);
    step(0, 0, 1, 8'hF0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 8'h74);
    chk("clr_after_f0_x", 32'(x0), 1);
    step(0, 1, 0, 0);
    mcount = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 8'h74);
      mcount += int'(m1);
    end
    chk("sat_x", 32'(x1), 4);
    chk("sat_moved_count", 32'(mcount), 4);
    for (int i = 0; i < 3000; i++) begin
      int pick[14] = '{'hE0, 'hF0, 'h74, 'h6B, 'h75, 'h72, 'h16, 'h1E, 'h26, 'h25, 'h76, 'h74, 'h72, 'h5A};
      int r = $urandom_range(0, 99);
      logic [7:0] b = r < 90 ? 8'(pick[$urandom_range(0, 13)]) : 8'($urandom);
      step(r == 0, r == 1, $urandom_range(0, 3) != 0, b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
